// File: rtl/abs_diff_pkg.sv
// Shared definitions for the approximate absolute-difference error checker
// and the generated approximate netlists that it measures.
package abs_diff_pkg;

   // Default operand/result sizing and error threshold used by the netlists
   localparam int DEF_W     = 2;
   localparam int DEF_RES_W = 3;
   localparam int DEF_ET    = 1;

   // Working width of abs_sub; callers zero-extend into it and truncate back
   localparam int ABS_W = 32;

   // Sweep controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Unsigned |x - y| without wrap: compare first, then subtract the smaller
   function automatic logic [ABS_W-1:0] abs_sub(input logic [ABS_W-1:0] x,
                                                input logic [ABS_W-1:0] y);
      logic [ABS_W-1:0] r;
      if (x >= y) begin
         r = x - y;
      end else begin
         r = y - x;
      end
      return r;
   endfunction

endpackage

// File: rtl/abs_diff_err_acc.sv
// Error statistics accumulator: compares one exact/approximate result pair per
// sample strobe and keeps the running max, counts, sum and first violating vector.
module abs_diff_err_acc
   import abs_diff_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int RES_W = DEF_RES_W,
   parameter int ET    = DEF_ET,
   parameter int CNT_W = 2*W+1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   sample,
   input  logic [RES_W-1:0]       exact,
   input  logic [RES_W-1:0]       approx,
   input  logic [2*W-1:0]         vec,
   output logic [RES_W-1:0]       max_err,
   output logic [CNT_W-1:0]       err_cnt,
   output logic [CNT_W-1:0]       viol_cnt,
   output logic [CNT_W+RES_W-1:0] err_sum,
   output logic [2*W-1:0]         first_fail
);

   localparam int               SUM_W = CNT_W + RES_W;
   localparam logic [ABS_W-1:0] ET_U  = ABS_W'(ET);

   logic [RES_W-1:0] err;
   logic             is_err;
   logic             is_viol;

   // Absolute error of the current pair and its classification
   always_comb begin
      err     = RES_W'(abs_sub(ABS_W'(exact), ABS_W'(approx)));
      is_err  = (err != '0);
      is_viol = (ABS_W'(err) > ET_U);
   end

   // Fold the current pair into the statistics; first_fail only latches while no violation has been counted yet
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         max_err    <= '0;
         err_cnt    <= '0;
         viol_cnt   <= '0;
         err_sum    <= '0;
         first_fail <= '0;
      end else if (sample) begin
         if (err > max_err) begin
            max_err <= err;
         end
         if (is_err) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
         err_sum <= err_sum + SUM_W'(err);
         if (is_viol) begin
            viol_cnt <= viol_cnt + CNT_W'(1);
            if (viol_cnt == '0) begin
               first_fail <= vec;
            end
         end
      end
   end

endmodule

// File: rtl/abs_diff_et_checker.sv
// Exhaustive sweep controller: walks every operand pair through an external
// approximate |a-b| datapath, waits LAT cycles per vector, and scores the
// sampled result against the exact difference.
module abs_diff_et_checker
   import abs_diff_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int RES_W = DEF_RES_W,
   parameter int LAT   = 0,
   parameter int ET    = DEF_ET,
   parameter int CNT_W = 2*W+1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   output logic [2*W-1:0]         dut_vec,
   input  logic [RES_W-1:0]       dut_res,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [RES_W-1:0]       max_err,
   output logic [CNT_W-1:0]       err_cnt,
   output logic [CNT_W-1:0]       viol_cnt,
   output logic [CNT_W+RES_W-1:0] err_sum,
   output logic [2*W-1:0]         first_fail
);

   localparam int WAIT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

   state_t            state;
   state_t            next_state;
   logic [2*W-1:0]    vec;
   logic [WAIT_W-1:0] wait_cnt;
   logic              pass_q;
   logic              at_lat;
   logic              last_vec;
   logic              clear;
   logic              sample;
   logic [W-1:0]      op_a;
   logic [W-1:0]      op_b;
   logic [RES_W-1:0]  exact;

   // Operand split and exact reference for the vector currently on the datapath
   always_comb begin
      op_a     = vec[W-1:0];
      op_b     = vec[2*W-1:W];
      exact    = RES_W'(abs_sub(ABS_W'(op_a), ABS_W'(op_b)));
      at_lat   = (wait_cnt == WAIT_W'(LAT));
      last_vec = &vec;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state plus the clear/sample strobes; abort beats the final sample so no done is produced
   always_comb begin
      next_state = state;
      clear      = 1'b0;
      sample     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               next_state = RUN;
               clear      = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               next_state = IDLE;
            end else if (at_lat) begin
               sample = 1'b1;
               if (last_vec) begin
                  next_state = DONE;
               end
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Vector/wait counters and the held pass flag; vector stays put until its wait reaches LAT
   always_ff @(posedge clk) begin
      if (rst) begin
         vec      <= '0;
         wait_cnt <= '0;
         pass_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  vec      <= '0;
                  wait_cnt <= '0;
                  pass_q   <= 1'b0;
               end
            end
            RUN: begin
               if (!abort) begin
                  if (at_lat) begin
                     wait_cnt <= '0;
                     if (!last_vec) begin
                        vec <= vec + (2*W)'(1);
                     end
                  end else begin
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
               end
            end
            DONE: begin
               pass_q <= (viol_cnt == '0);
            end
            default: begin
               pass_q <= 1'b0;
            end
         endcase
      end
   end

   abs_diff_err_acc #(
      .W     (W),
      .RES_W (RES_W),
      .ET    (ET),
      .CNT_W (CNT_W)
   ) u_acc (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .sample     (sample),
      .exact      (exact),
      .approx     (dut_res),
      .vec        (vec),
      .max_err    (max_err),
      .err_cnt    (err_cnt),
      .viol_cnt   (viol_cnt),
      .err_sum    (err_sum),
      .first_fail (first_fail)
   );

   // Status outputs; in DONE pass reflects the counts that already include the final sample
   always_comb begin
      dut_vec = vec;
      busy    = (state == RUN);
      done    = (state == DONE);
      pass    = (state == DONE) ? (viol_cnt == '0) : pass_q;
   end

endmodule
